// File: rtl/iter_normalizer.sv
// ---------------------------------------------------------------------------
// iter_normalizer
//
// Recovers a shift amount from data: shifts the accepted operand one bit per
// cycle until its target bit is 1. The target is the MSB in left mode and
// the LSB in right mode. It returns the normalized word, the number of
// positions shifted, and a flag for an all-zero operand.
//
// Optional feature, enabled by defining ITER_NORMALIZER_MAX_AMT_EN:
//   - adds a per-operand shift ceiling (max_amt_i);
//   - adds a flag (limited_o) set when that ceiling stopped the shifting.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   block can accept an operand (only in IDLE)
//   a_i          operand
//   mode_i       0 = left-normalize (MSB target), 1 = right-normalize (LSB)
//   max_amt_i    [macro only] shift ceiling, sampled at accept
//   limited_o    [macro only] result stopped by the ceiling
//   out_valid_o  result valid (held until consumed)
//   out_ready_i  consumer takes the result
//   y_o          normalized word
//   amt_o        positions shifted
//   zero_o       operand was all zeros
// ---------------------------------------------------------------------------
module iter_normalizer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic             mode_i,
`ifdef ITER_NORMALIZER_MAX_AMT_EN
  input  logic [AMT_W-1:0] max_amt_i,
  output logic             limited_o,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic [AMT_W-1:0] amt_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             mode_q, mode_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             target_bit;
  logic             at_limit;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
  logic [AMT_W-1:0] max_q, max_d;
  logic             lim_q, lim_d;
`endif

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    y_d        = y_q;
    amt_d      = amt_q;
    zero_d     = zero_q;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
    max_d      = max_q;
    lim_d      = lim_q;
    at_limit   = (cnt_q == max_q);
`else
    // Natural termination always occurs by a count of WIDTH-1.
    at_limit   = 1'b0;
`endif
    target_bit = mode_q ? sreg_q[0] : sreg_q[WIDTH-1];

    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_q) begin
          sreg_d  = a_i;
          mode_d  = mode_i;
          cnt_d   = '0;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
          max_d   = max_amt_i;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sreg_q == '0) begin
          state_d = DONE;
          y_d     = '0;
          amt_d   = '0;
          zero_d  = 1'b1;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
          lim_d   = 1'b0;
`endif
        end else if (target_bit || at_limit) begin
          state_d = DONE;
          y_d     = sreg_q;
          amt_d   = cnt_q;
          zero_d  = 1'b0;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
          // A set target bit takes precedence over the ceiling.
          lim_d   = ~target_bit;
`endif
        end else begin
          sreg_d = mode_q ? (sreg_q >> 1) : (sreg_q << 1);
          cnt_d  = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags are registered and follow the next state.
    // DONE therefore never accepts in the same cycle as the handshake.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      y_q         <= '0;
      amt_q       <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
      max_q       <= '0;
      lim_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      amt_q       <= amt_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
      max_q       <= max_d;
      lim_q       <= lim_d;
`endif
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign amt_o       = amt_q;
  assign zero_o      = zero_q;
`ifdef ITER_NORMALIZER_MAX_AMT_EN
  assign limited_o   = lim_q;
`endif

endmodule
